sm_als_reader: RTL



---
 rtl/sm_als_reader_if.sv | 11 +
 rtl/sm_als_reader.sv | 62 ++++++
 2 files changed

// File: rtl/sm_als_reader_if.sv
// sm_als_reader_if: bus side of the light sensor reader (start/auto requests in; busy/valid/value/frames status out)
interface sm_als_reader_if;
  logic start;
  logic auto;
  logic busy;
  logic valid;
  logic [7:0] value;
  logic [15:0] frames;
  modport master (output start, auto, input busy, valid, value, frames);
  modport slave (input start, auto, output busy, valid, value, frames);
endinterface

// File: rtl/sm_als_reader.sv
// sm_als_reader: SPI reader for an 8-bit ambient light ADC; pins alsCS/alsSCK/alsSDO, bus via sm_als_reader_if.slave
module sm_als_reader #(
  parameter int SCK_HALF = 4,
  parameter int QUIET = 8
) (
  input logic clk,
  input logic rst,
  sm_als_reader_if.slave bus,
  input logic alsSDO,
  output logic alsCS,
  output logic alsSCK
);
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_LOW, ST_HIGH, ST_QUIET} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [3:0] bits;
  logic [11:0] shift;
  logic sdo_m, sdo_s;
  logic done, sample, fin;
  always_comb begin
    done = cnt == ((state == ST_QUIET) ? 8'(QUIET - 1) : 8'(SCK_HALF - 1));
    sample = state == ST_HIGH && done;
    fin = sample && bits == 4'd15;
    state_n = state;
    case (state)
      ST_IDLE: state_n = (bus.start || bus.auto) ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_n = done ? ST_LOW : ST_SETUP;
      ST_LOW: state_n = done ? ST_HIGH : ST_LOW;
      ST_HIGH: state_n = done ? (fin ? ST_QUIET : ST_LOW) : ST_HIGH;
      ST_QUIET: state_n = done ? (bus.auto ? ST_SETUP : ST_IDLE) : ST_QUIET;
      default: state_n = ST_IDLE;
    endcase
  end
  assign alsCS = state == ST_IDLE || state == ST_QUIET;
  assign alsSCK = state != ST_LOW;
  assign bus.busy = state != ST_IDLE;
  // Only the 12 newest bits are kept: before the 16th shift, shift[11:4] already
  // holds frame bits 3..10, i.e. what a full 16-bit register shows at [12:5] afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      bits <= '0;
      shift <= '0;
      sdo_m <= 1'b1;
      sdo_s <= 1'b1;
      bus.valid <= 1'b0;
      bus.value <= '0;
      bus.frames <= '0;
    end else begin
      state <= state_n;
      sdo_m <= alsSDO;
      sdo_s <= sdo_m;
      cnt <= (state == ST_IDLE || done) ? '0 : cnt + 8'd1;
      bits <= bits + 4'(sample);
      shift <= sample ? {shift[10:0], sdo_s} : shift;
      bus.valid <= fin;
      bus.value <= fin ? shift[11:4] : bus.value;
      bus.frames <= bus.frames + 16'(fin);
    end
  end
endmodule
